// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: BCD real-time clock with a prescaled seconds tick, a
// three-state time-set handshake and an optional alarm.
//
// Optional feature macro: RTC_ALARM_EN. When it is defined, the alarm
// registers and the alarm output are present. When it is undefined, alarm is
// tied 0 and the al_* inputs are ignored.
//
// Ports
//   hundred_clk              sole clock
//   rst                      synchronous, active-low reset
//   run                      1 = prescaler and time advance, 0 = frozen
//   hrm,hrl,minm,minl,       BCD time digits
//   secm,secl
//   pm                       PM flag (12-hour build only, else 0)
//   sec_pulse                one-cycle pulse when new seconds are registered
//   ld_valid,ld_hr,ld_min,   time-set request (BCD); ld_pm used in 12-hour build
//   ld_sec,ld_pm
//   ld_ready                 high while the set FSM is idle
//   ld_err                   one-cycle pulse when a requested time is rejected
//   al_wr,al_hr,al_min,      alarm programming, acknowledge and status
//   al_pm,al_on,al_ack,alarm
module bcd_timekeeper #(
  parameter int TICKS_PER_SEC = 100,
  parameter bit HOUR_24       = 1'b1
) (
  input  logic       hundred_clk,
  input  logic       rst,
  input  logic       run,
  output logic [3:0] hrm,
  output logic [3:0] hrl,
  output logic [3:0] minm,
  output logic [3:0] minl,
  output logic [3:0] secm,
  output logic [3:0] secl,
  output logic       pm,
  output logic       sec_pulse,
  input  logic       ld_valid,
  input  logic [7:0] ld_hr,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_sec,
  input  logic       ld_pm,
  output logic       ld_ready,
  output logic       ld_err,
  input  logic       al_wr,
  input  logic [7:0] al_hr,
  input  logic [7:0] al_min,
  input  logic       al_pm,
  input  logic       al_on,
  input  logic       al_ack,
  output logic       alarm
);

  localparam logic [15:0] TERM = 16'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
  state_t state, state_nxt;

  logic [15:0] cnt;
  logic        tick;
  logic        pm_r;
  logic [7:0]  cap_hr, cap_min, cap_sec;
  logic        cap_pm, cap_ok;
  logic        load;
  logic [3:0]  n_hrm, n_hrl, n_minm, n_minl, n_secm, n_secl;
  logic        n_pm;

  function automatic logic time_ok(input logic [7:0] h, input logic [7:0] m,
                                   input logic [7:0] s);
    logic ok;
    ok = (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
         (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9) &&
         (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
    if (HOUR_24)
      ok = ok && ((h[7:4] < 4'd2) || (h[7:4] == 4'd2 && h[3:0] <= 4'd3));
    else
      ok = ok && ((h[7:4] == 4'd0 && h[3:0] != 4'd0) ||
                  (h[7:4] == 4'd1 && h[3:0] <= 4'd2));
    return ok;
  endfunction

  // The terminal prescaler cycle is the seconds tick.
  assign tick     = run && (cnt == TERM);
  assign load     = (state == COMMIT) && cap_ok;
  assign ld_err   = (state == COMMIT) && !cap_ok;
  assign ld_ready = (state == IDLE);
  assign pm       = HOUR_24 ? 1'b0 : pm_r;

  // Set FSM
  always_ff @(posedge hundred_clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_valid) state_nxt = CHECK;
      CHECK:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture and validation; only meaningful while the FSM is busy, so no reset.
  always_ff @(posedge hundred_clk) begin
    if (state == IDLE && ld_valid) begin
      cap_hr  <= ld_hr;
      cap_min <= ld_min;
      cap_sec <= ld_sec;
      cap_pm  <= ld_pm;
    end
    if (state == CHECK) cap_ok <= time_ok(cap_hr, cap_min, cap_sec);
  end

  // Next time after one second: BCD carry cascade.
  always_comb begin
    n_hrm  = hrm;
    n_hrl  = hrl;
    n_minm = minm;
    n_minl = minl;
    n_secm = secm;
    n_secl = secl;
    n_pm   = pm_r;
    if (secl != 4'd9) n_secl = secl + 4'd1;
    else begin
      n_secl = 4'd0;
      if (secm != 4'd5) n_secm = secm + 4'd1;
      else begin
        n_secm = 4'd0;
        if (minl != 4'd9) n_minl = minl + 4'd1;
        else begin
          n_minl = 4'd0;
          if (minm != 4'd5) n_minm = minm + 4'd1;
          else begin
            n_minm = 4'd0;
            if (HOUR_24) begin
              if (hrm == 4'd2 && hrl == 4'd3) begin
                n_hrm = 4'd0;
                n_hrl = 4'd0;
              end else if (hrl == 4'd9) begin
                n_hrm = hrm + 4'd1;
                n_hrl = 4'd0;
              end else n_hrl = hrl + 4'd1;
            end else begin
              // 12 -> 01 keeps pm; 11 -> 12 flips it.
              if (hrm == 4'd1 && hrl == 4'd2) begin
                n_hrm = 4'd0;
                n_hrl = 4'd1;
              end else if (hrm == 4'd1 && hrl == 4'd1) begin
                n_hrl = 4'd2;
                n_pm  = ~pm_r;
              end else if (hrl == 4'd9) begin
                n_hrm = 4'd1;
                n_hrl = 4'd0;
              end else n_hrl = hrl + 4'd1;
            end
          end
        end
      end
    end
  end

  // Prescaler and time registers; a valid commit overrides any tick.
  always_ff @(posedge hundred_clk) begin
    if (!rst) begin
      cnt       <= 16'd0;
      sec_pulse <= 1'b0;
      hrm       <= HOUR_24 ? 4'd0 : 4'd1;
      hrl       <= HOUR_24 ? 4'd0 : 4'd2;
      minm      <= 4'd0;
      minl      <= 4'd0;
      secm      <= 4'd0;
      secl      <= 4'd0;
      pm_r      <= 1'b0;
    end else begin
      sec_pulse <= tick && !load;
      if (load) begin
        cnt  <= 16'd0;
        hrm  <= cap_hr[7:4];
        hrl  <= cap_hr[3:0];
        minm <= cap_min[7:4];
        minl <= cap_min[3:0];
        secm <= cap_sec[7:4];
        secl <= cap_sec[3:0];
        pm_r <= HOUR_24 ? 1'b0 : cap_pm;
      end else begin
        if (run) cnt <= tick ? 16'd0 : cnt + 16'd1;
        if (tick) begin
          hrm  <= n_hrm;
          hrl  <= n_hrl;
          minm <= n_minm;
          minl <= n_minl;
          secm <= n_secm;
          secl <= n_secl;
          pm_r <= n_pm;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic [7:0] al_hr_r, al_min_r;
  logic       al_pm_r, al_on_r;
  logic       al_match;

  // Compared against the time about to be registered by the tick.
  assign al_match = al_on_r && ({n_hrm, n_hrl} == al_hr_r) &&
                    ({n_minm, n_minl} == al_min_r) &&
                    (n_secm == 4'd0) && (n_secl == 4'd0) &&
                    (HOUR_24 || (n_pm == al_pm_r));

  always_ff @(posedge hundred_clk) begin
    if (!rst) begin
      al_hr_r  <= 8'd0;
      al_min_r <= 8'd0;
      al_pm_r  <= 1'b0;
      al_on_r  <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      if (al_wr) begin
        al_hr_r  <= al_hr;
        al_min_r <= al_min;
        al_pm_r  <= al_pm;
        al_on_r  <= al_on;
      end
      if (tick && !load && al_match) alarm <= 1'b1;
      else if (al_ack)               alarm <= 1'b0;
    end
  end
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{al_wr, al_hr, al_min, al_pm, al_on, al_ack};
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Testbench for bcd_timekeeper: one 24-hour and one 12-hour instance share the
// same stimulus and are compared every cycle against a seconds-of-day model.
module tb_bcd_timekeeper;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0, run = 1'b0, ld_valid = 1'b0, ld_pm = 1'b0;
  logic [7:0] ld_hr = 8'h00, ld_min = 8'h00, ld_sec = 8'h00;
  logic       al_wr = 1'b0, al_pm = 1'b0, al_on = 1'b0, al_ack = 1'b0;
  logic [7:0] al_hr = 8'h00, al_min = 8'h00;

  logic [3:0] hrm_a, hrl_a, minm_a, minl_a, secm_a, secl_a;
  logic [3:0] hrm_b, hrl_b, minm_b, minl_b, secm_b, secl_b;
  logic       pm_a, pm_b;
  logic       sp[2], rdy[2], err[2], alm[2];
  logic [24:0] tv[2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_timekeeper #(.TICKS_PER_SEC(T), .HOUR_24(1'b1)) dut24 (
    .hundred_clk(clk), .rst(rst), .run(run),
    .hrm(hrm_a), .hrl(hrl_a), .minm(minm_a), .minl(minl_a), .secm(secm_a), .secl(secl_a),
    .pm(pm_a), .sec_pulse(sp[0]),
    .ld_valid(ld_valid), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec), .ld_pm(ld_pm),
    .ld_ready(rdy[0]), .ld_err(err[0]),
    .al_wr(al_wr), .al_hr(al_hr), .al_min(al_min), .al_pm(al_pm), .al_on(al_on),
    .al_ack(al_ack), .alarm(alm[0]));

  bcd_timekeeper #(.TICKS_PER_SEC(T), .HOUR_24(1'b0)) dut12 (
    .hundred_clk(clk), .rst(rst), .run(run),
    .hrm(hrm_b), .hrl(hrl_b), .minm(minm_b), .minl(minl_b), .secm(secm_b), .secl(secl_b),
    .pm(pm_b), .sec_pulse(sp[1]),
    .ld_valid(ld_valid), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec), .ld_pm(ld_pm),
    .ld_ready(rdy[1]), .ld_err(err[1]),
    .al_wr(al_wr), .al_hr(al_hr), .al_min(al_min), .al_pm(al_pm), .al_on(al_on),
    .al_ack(al_ack), .alarm(alm[1]));

  assign tv[0] = {hrm_a, hrl_a, minm_a, minl_a, secm_a, secl_a, pm_a};
  assign tv[1] = {hrm_b, hrl_b, minm_b, minl_b, secm_b, secl_b, pm_b};

  // Reference model: time as seconds since midnight, index 0 = 24h, 1 = 12h.
  int m_cnt[2], m_t[2], c_t[2];
  bit m_sp[2], m_ok[2], m_al[2];
  int phase;            // 0 idle, 1 validating, 2 committing
  bit a_on, a_pm;
  int a_hr, a_min;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int b2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int hour24(input int mode, input int hh, input bit p);
    return (mode == 0) ? hh : (hh % 12) + (p ? 12 : 0);
  endfunction

  function automatic logic [24:0] disp(input int mode, input int t);
    int h24, h, mm, ss;
    bit p;
    h24 = t / 3600;
    mm  = (t / 60) % 60;
    ss  = t % 60;
    h   = (mode == 0) ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
    p   = (mode == 1) && (h24 >= 12);
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), p};
  endfunction

  function automatic bit req_ok(input int mode);
    int hh;
    if (ld_hr[7:4] > 9 || ld_hr[3:0] > 9 || ld_min[7:4] > 9 || ld_min[3:0] > 9 ||
        ld_sec[7:4] > 9 || ld_sec[3:0] > 9) return 1'b0;
    if (b2i(ld_min) > 59 || b2i(ld_sec) > 59) return 1'b0;
    hh = b2i(ld_hr);
    return (mode == 0) ? (hh <= 23) : (hh >= 1 && hh <= 12);
  endfunction

  task automatic model_edge();
    bit tk;
    int tgt;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        m_cnt[m] = 0; m_t[m] = 0; m_sp[m] = 0; m_al[m] = 0;
      end
      phase = 0; a_on = 0; a_pm = 0; a_hr = 0; a_min = 0;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      tk  = run && (m_cnt[m] == T - 1);
      tgt = hour24(m, a_hr, a_pm) * 3600 + a_min * 60;
      if (phase == 2 && m_ok[m]) begin
        m_t[m] = c_t[m]; m_cnt[m] = 0; m_sp[m] = 0;
        if (al_ack) m_al[m] = 0;
      end else begin
        m_sp[m] = tk;
        if (run) m_cnt[m] = tk ? 0 : m_cnt[m] + 1;
        if (tk) m_t[m] = (m_t[m] + 1) % 86400;
        if (tk && a_on && m_t[m] == tgt) m_al[m] = 1;
        else if (al_ack)                 m_al[m] = 0;
      end
    end
    if (al_wr) begin
      a_hr = b2i(al_hr); a_min = b2i(al_min); a_pm = al_pm; a_on = al_on;
    end
    case (phase)
      0: if (ld_valid) begin
        for (int m = 0; m < 2; m++) begin
          m_ok[m] = req_ok(m);
          c_t[m]  = hour24(m, b2i(ld_hr), ld_pm) * 3600 + b2i(ld_min) * 60 + b2i(ld_sec);
        end
        phase = 1;
      end
      1: phase = 2;
      default: phase = 0;
    endcase
  endtask

  task automatic check_all();
    bit ea;
    for (int m = 0; m < 2; m++) begin
`ifdef RTC_ALARM_EN
      ea = m_al[m];
`else
      ea = 1'b0;
`endif
      chk($sformatf("time%0d", m), 32'(tv[m]), 32'(disp(m, m_t[m])));
      chk($sformatf("sec_pulse%0d", m), 32'(sp[m]), 32'(m_sp[m]));
      chk($sformatf("ld_ready%0d", m), 32'(rdy[m]), 32'(phase == 0));
      chk($sformatf("ld_err%0d", m), 32'(err[m]), 32'(phase == 2 && !m_ok[m]));
      chk($sformatf("alarm%0d", m), 32'(alm[m]), 32'(ea));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Issue one set request and follow it through CHECK and COMMIT.
  task automatic do_load(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                         input bit p, output int low, output int e24, output int e12);
    ld_hr = h; ld_min = mi; ld_sec = s; ld_pm = p; ld_valid = 1'b1;
    low = 0; e24 = 0; e12 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      ld_valid = 1'b0;
      if (!rdy[0]) low++;
      if (err[0]) e24++;
      if (err[1]) e12++;
    end
  endtask

  initial begin
    int low, e24, e12, pulses, last, gap_bad, cyc;
    bit exp_al;
`ifdef RTC_ALARM_EN
    exp_al = 1'b1;
`else
    exp_al = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
    steps(2);
    chk("rst_time24", 32'(tv[0]), 32'h0);
    chk("rst_time12", 32'(tv[1]), 32'({24'h120000, 1'b0}));
    rst = 1'b1;

    // One minute of free running.
    run = 1'b1; pulses = 0; last = 0; gap_bad = 0;
    for (cyc = 1; cyc <= 240; cyc++) begin
      step();
      if (sp[0]) begin
        if (pulses > 0 && cyc - last != T) gap_bad++;
        pulses++; last = cyc;
      end
    end
    chk("pulse_count", 32'(pulses), 32'd60);
    chk("pulse_gap", 32'(gap_bad), 32'd0);
    chk("one_minute", 32'(tv[0]), 32'({24'h000100, 1'b0}));

    // Midnight rollover (24h) and ready window.
    do_load(8'h23, 8'h59, 8'h58, 1'b0, low, e24, e12);
    chk("rdy_window", 32'(low), 32'd2);
    chk("err_23h_24", 32'(e24), 32'd0);
    chk("err_23h_12", 32'(e12), 32'd1);
    steps(2 * T);
    chk("midnight24", 32'(tv[0]), 32'h0);

    // 12-hour noon and 12 -> 01 transitions.
    do_load(8'h11, 8'h59, 8'h59, 1'b0, low, e24, e12);
    steps(T);
    chk("noon12", 32'(tv[1]), 32'({24'h120000, 1'b1}));
    do_load(8'h12, 8'h59, 8'h59, 1'b1, low, e24, e12);
    steps(T);
    chk("one_pm12", 32'(tv[1]), 32'({24'h010000, 1'b1}));

    // Rejected loads.
    do_load(8'h24, 8'h00, 8'h00, 1'b0, low, e24, e12);
    chk("err_24h", 32'(e24), 32'd1);
    do_load(8'h12, 8'h60, 8'h00, 1'b0, low, e24, e12);
    chk("err_min60", 32'(e12), 32'd1);
    steps(2 * T);

    // Alarm.
    al_hr = 8'h07; al_min = 8'h30; al_pm = 1'b0; al_on = 1'b1; al_wr = 1'b1;
    step();
    al_wr = 1'b0;
    do_load(8'h07, 8'h29, 8'h59, 1'b0, low, e24, e12);
    steps(T);
    chk("alarm_set24", 32'(alm[0]), 32'(exp_al));
    chk("alarm_set12", 32'(alm[1]), 32'(exp_al));
    al_ack = 1'b1; step(); al_ack = 1'b0;
    chk("alarm_ack", 32'(alm[0]), 32'd0);
    do_load(8'h07, 8'h30, 8'h00, 1'b0, low, e24, e12);
    steps(2);
    chk("alarm_on_load", 32'(alm[0]), 32'd0);

    // Reset during CHECK, then reset while stopped.
    ld_hr = 8'h24; ld_min = 8'h00; ld_sec = 8'h00; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_check24", 32'(tv[0]), 32'h0);
    chk("rst_check_rdy", 32'(rdy[0]), 32'd1);
    steps(3);
    steps(5);
    run = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_stop12", 32'(tv[1]), 32'({24'h120000, 1'b0}));
    steps(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) != 0);
      run    = ($urandom % 8 != 0);
      al_ack = ($urandom % 8 == 0);
      ld_valid = ($urandom % 12 == 0);
      ld_pm  = $urandom % 2;
      if ($urandom % 8 == 0) begin
        ld_hr = 8'($urandom); ld_min = 8'($urandom); ld_sec = 8'($urandom);
      end else begin
        ld_hr  = i2b(int'($urandom_range(0, 25)));
        ld_min = i2b(int'($urandom_range(0, 61)));
        ld_sec = ($urandom % 2 == 0) ? 8'h59 : i2b(int'($urandom_range(0, 61)));
      end
      al_wr = ($urandom % 40 == 0);
      if (al_wr) begin
        al_hr  = i2b(int'($urandom_range(1, 12)));
        al_min = i2b(int'($urandom_range(0, 59)));
        al_pm  = $urandom % 2;
        al_on  = ($urandom % 4 != 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_timekeeper.md
BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100: hundred_clk cycles per second; legal range 2..65535.
REQ-002 Parameter HOUR_24, default 1: 1 = 24-hour format, 0 = 12-hour format with pm flag.
REQ-003 Reset rst, synchronous, active-low; clock hundred_clk.
REQ-004 Port hundred_clk, input, 1 bit: sole clock.
REQ-005 Port rst, input, 1 bit: synchronous active-low reset.
REQ-006 Port run, input, 1 bit: 1 = timekeeping advances; 0 = prescaler and time frozen.
REQ-007 Ports hrm, hrl, minm, minl, secm, secl, output, 4 bits each: BCD time digits.
REQ-008 Port pm, output, 1 bit: PM flag in 12-hour mode; constant 0 when HOUR_24=1.
REQ-009 Port sec_pulse, output, 1 bit: one-cycle pulse on the cycle the seconds digits advance.
REQ-010 Ports ld_valid (in, 1), ld_hr (in, 8, BCD), ld_min (in, 8, BCD), ld_sec (in, 8, BCD), ld_pm (in, 1): time-set request.
REQ-011 Ports ld_ready (out, 1) and ld_err (out, 1): set handshake and rejection pulse.
REQ-012 Ports al_wr (in, 1), al_hr (in, 8), al_min (in, 8), al_pm (in, 1), al_on (in, 1), al_ack (in, 1), alarm (out, 1): alarm programming and alarm status.

Function
REQ-013 Prescaler counts 0..TICKS_PER_SEC-1 while run=1 and wraps to 0 at the terminal count; the terminal cycle is the second tick.
REQ-014 On each second tick, digits increment as a BCD cascade: secl 9->0 carries into secm, secm 5->0 carries into minl, minl 9->0 carries into minm, and minm 5->0 carries into the hour.
REQ-015 HOUR_24=1: hour advances 00..23; 23:59:59 -> 00:00:00.
REQ-016 HOUR_24=0: hour sequence is 12,01..11; 11:59:59 -> 12:00:00 toggles pm; 12:59:59 -> 01:00:00 with pm unchanged.
REQ-017 sec_pulse is asserted in the same cycle the new digits are registered, i.e. one cycle after the second tick.
REQ-018 Set FSM states: IDLE (ld_ready=1), CHECK (ld_ready=0), COMMIT (ld_ready=0).
REQ-019 Transitions: IDLE->CHECK when ld_valid=1 (inputs captured); CHECK->COMMIT unconditionally; COMMIT->IDLE unconditionally.
REQ-020 CHECK validates the captured time; it is invalid if any nibble >9, minutes >59, seconds >59, or hours are outside 00..23 (24h) or 01..12 (12h).
REQ-021 COMMIT with valid data: digits and pm are loaded (pm ignored in 24h), the prescaler is cleared, and any tick in that cycle is discarded.
REQ-022 COMMIT with invalid data: time is left unchanged and ld_err pulses for one cycle.
REQ-023 While the FSM is in CHECK, timekeeping continues normally.
REQ-024 al_wr=1 latches al_hr, al_min, al_pm and al_on into the alarm registers, regardless of FSM state.
REQ-025 alarm sets when al_on=1 and the newly registered time equals hh:mm:00 (plus pm in 12h); this applies to tick-driven updates only, never to a COMMIT load.
REQ-026 alarm stays high until an al_ack cycle; if set and al_ack coincide, set wins.

Reset
REQ-027 rst=0 at a hundred_clk edge clears the prescaler and alarm and returns the FSM to IDLE.
REQ-028 Reset time is 00:00:00 when HOUR_24=1, or 12:00:00 with pm=0 when HOUR_24=0.
REQ-029 Reset clears sec_pulse, ld_err, the alarm registers (al_on=0) and sets ld_ready=1 on the following cycle.
REQ-030 Reset mid-load aborts the load, and no commit occurs.

Configuration
REQ-031 Macro RTC_ALARM_EN defined: alarm logic per REQ-024..026 is present.
REQ-032 Macro RTC_ALARM_EN undefined: no alarm registers exist, alarm is tied 0, and al_wr, al_hr, al_min, al_pm, al_on and al_ack are ignored.

Verification (TICKS_PER_SEC=4)
REQ-033 Reset, run=1 for 240 cycles -> time 00:01:00, 60 sec_pulse pulses, each exactly 4 cycles apart.
REQ-034 HOUR_24=1: load 23:59:58, wait 2 ticks -> 00:00:00; the ld_ready low window is exactly 2 cycles.
REQ-035 HOUR_24=0: load 11:59:59 pm=0, 1 tick -> 12:00:00 pm=1; load 12:59:59, 1 tick -> 01:00:00 with pm unchanged.
REQ-036 Load 24:00:00 (24h) or 12:60:00 -> ld_err pulses once and time keeps counting from its prior value.
REQ-037 RTC_ALARM_EN: alarm 07:30 on, load 07:29:59, 1 tick -> alarm=1; al_ack -> 0; reloading 07:30:00 -> alarm stays 0.
REQ-038 Assert rst=0 during CHECK, and separately with run=0 -> reset values per REQ-028 are restored next cycle and no ld_err occurs.
